booth16_iter_mult: RTL



---
 rtl/fused_fp_pkg.sv | 26 ++
 rtl/Radix16_Booth_Encoder.sv | 34 +++
 rtl/Radix16_Booth_Sel.sv | 37 +++
 rtl/csa.sv | 19 +
 rtl/booth16_iter_mult.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/fused_fp_pkg.sv
// Shared types and helpers for the fused FP datapath: multiplier FSM states,
// radix-16 digit count and Booth window extraction.
package fused_fp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Widest significand the window helper can address.
    localparam int unsigned MAX_WIDTH = 64;

    function automatic int unsigned ndig_of(input int unsigned width);
        return (width + 4) / 4;
    endfunction

    // Window {y[4d+3:4d], y[4d-1]} with y[-1]=0 and bits above the operand reading as 0.
    function automatic logic [4:0] booth_window(input logic [MAX_WIDTH-1:0] y,
                                                input logic [7:0]           dig);
        logic [MAX_WIDTH+4:0] ext;
        ext = {4'b0000, y, 1'b0} >> {dig, 2'b00};
        return ext[4:0];
    endfunction

endpackage

// File: rtl/Radix16_Booth_Encoder.sv
// Precomputes the unsigned multiples 0..8 of the multiplicand for radix-16 Booth selection.
module Radix16_Booth_Encoder #(
    parameter int unsigned WIDTH = 24
) (
    input  logic [WIDTH-1:0]            x,
    output logic [8:0][WIDTH+2:0]       mult_c
);

    localparam int unsigned MW = WIDTH + 3;

    logic [MW-1:0] x1_c;
    logic [MW-1:0] x2_c;
    logic [MW-1:0] x3_c;
    logic [MW-1:0] x4_c;
    logic [MW-1:0] x8_c;

    assign x1_c = MW'(x);
    assign x2_c = x1_c << 1;
    assign x4_c = x1_c << 2;
    assign x8_c = x1_c << 3;
    assign x3_c = x1_c + x2_c;

    // Odd multiples need a carry-propagate add; even ones are shifts.
    assign mult_c[0] = '0;
    assign mult_c[1] = x1_c;
    assign mult_c[2] = x2_c;
    assign mult_c[3] = x3_c;
    assign mult_c[4] = x4_c;
    assign mult_c[5] = x1_c + x4_c;
    assign mult_c[6] = x3_c << 1;
    assign mult_c[7] = x8_c - x1_c;
    assign mult_c[8] = x8_c;

endmodule

// File: rtl/Radix16_Booth_Sel.sv
// Decodes one 5-bit Booth window into a signed partial product (digit -8..+8 times X).
module Radix16_Booth_Sel #(
    parameter int unsigned WIDTH = 24
) (
    input  logic [4:0]                  window,
    input  logic [8:0][WIDTH+2:0]       mult,
    output logic [WIDTH+3:0]            pp_c
);

    localparam int unsigned MW = WIDTH + 3;
    localparam int unsigned PW = WIDTH + 4;

    logic [3:0]    low_c;
    logic [3:0]    idx_c;
    logic [MW-1:0] mag_c;

    always_comb begin
        low_c = {1'b0, window[3:1]} + {3'b000, window[0]};
        idx_c = window[4] ? (4'd8 - low_c) : low_c;
        mag_c = '0;
        case (idx_c)
            4'd0:    mag_c = mult[0];
            4'd1:    mag_c = mult[1];
            4'd2:    mag_c = mult[2];
            4'd3:    mag_c = mult[3];
            4'd4:    mag_c = mult[4];
            4'd5:    mag_c = mult[5];
            4'd6:    mag_c = mult[6];
            4'd7:    mag_c = mult[7];
            4'd8:    mag_c = mult[8];
            default: mag_c = '0;
        endcase
        // Negative digits: two's complement as invert plus LSB increment.
        pp_c = window[4] ? (~{1'b0, mag_c} + PW'(1)) : {1'b0, mag_c};
    end

endmodule

// File: rtl/csa.sv
// Generic 3:2 carry-save compressor; PLUS_ONE injects a one into the carry LSB.
module csa #(
    parameter int unsigned WIDTH    = 48,
    parameter bit          PLUS_ONE = 1'b0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] sum_c,
    output logic [WIDTH-1:0] carry_c
);

    logic [WIDTH-1:0] maj_c;

    assign sum_c   = a ^ b ^ c;
    assign maj_c   = (a & b) | (a & c) | (b & c);
    assign carry_c = {maj_c[WIDTH-2:0], PLUS_ONE};

endmodule

// File: rtl/booth16_iter_mult.sv
// Iterative radix-16 Booth significand multiplier: one digit per cycle into a CSA
// accumulator, registered final add. BOOTH16_ITER_EARLY_EXIT_EN stops on all-zero upper digits.
module booth16_iter_mult
    import fused_fp_pkg::*;
#(
    parameter int unsigned WIDTH = 24
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [WIDTH-1:0]     Multiplicand,
    input  logic [WIDTH-1:0]     Multiplier,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [2*WIDTH-1:0]   Product
);

    localparam int unsigned NDIG = ndig_of(WIDTH);
    localparam int unsigned MW   = WIDTH + 3;
    localparam int unsigned PW   = WIDTH + 4;
    localparam int unsigned AW   = 2 * WIDTH;
    localparam int unsigned CW   = $clog2(NDIG);

    mult_state_t         state_q;
    mult_state_t         state_d;
    logic [WIDTH-1:0]    x_q;
    logic [WIDTH-1:0]    x_d;
    logic [WIDTH-1:0]    y_q;
    logic [WIDTH-1:0]    y_d;
    logic [AW-1:0]       sum_q;
    logic [AW-1:0]       sum_d;
    logic [AW-1:0]       carry_q;
    logic [AW-1:0]       carry_d;
    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       cnt_d;
    logic [AW-1:0]       product_d;

    logic [8:0][MW-1:0]  mult_c;
    logic [4:0]          window_c;
    logic [PW-1:0]       pp_c;
    logic [AW-1:0]       pp_shift_c;
    logic [AW-1:0]       csa_sum_c;
    logic [AW-1:0]       csa_carry_c;
    logic                last_digit_c;

    Radix16_Booth_Encoder #(
        .WIDTH  (WIDTH)
    ) u_enc (
        .x      (x_q),
        .mult_c (mult_c)
    );

    assign window_c = booth_window(MAX_WIDTH'(y_q), 8'(cnt_q));

    Radix16_Booth_Sel #(
        .WIDTH  (WIDTH)
    ) u_sel (
        .window (window_c),
        .mult   (mult_c),
        .pp_c   (pp_c)
    );

    // Sign-extend the digit product and align it to digit position cnt.
    assign pp_shift_c = {{(AW-PW){pp_c[PW-1]}}, pp_c} << {cnt_q, 2'b00};

    csa #(
        .WIDTH    (AW),
        .PLUS_ONE (1'b0)
    ) u_csa (
        .a       (sum_q),
        .b       (carry_q),
        .c       (pp_shift_c),
        .sum_c   (csa_sum_c),
        .carry_c (csa_carry_c)
    );

`ifdef BOOTH16_ITER_EARLY_EXIT_EN
    // Remaining digits are zero once Y has no set bit at or above 4(cnt+1)-1.
    assign last_digit_c = (cnt_q == CW'(NDIG - 1)) ||
                          ((y_q >> (32'({cnt_q, 2'b00}) + 32'd3)) == '0);
`else
    assign last_digit_c = (cnt_q == CW'(NDIG - 1));
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        product_d = Product;
        case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    x_d     = Multiplicand;
                    y_d     = Multiplier;
                    sum_d   = '0;
                    carry_d = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = csa_sum_c;
                carry_d = csa_carry_c;
                cnt_d   = cnt_q + CW'(1);
                if (last_digit_c) begin
                    product_d = csa_sum_c + csa_carry_c;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            sum_q     <= '0;
            carry_q   <= '0;
            cnt_q     <= '0;
            IN_READY  <= 1'b1;
            OUT_VALID <= 1'b0;
            Product   <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            IN_READY  <= (state_d == IDLE);
            OUT_VALID <= (state_d == DONE);
            Product   <= product_d;
        end
    end

endmodule
